pixel_stream_packer: RTL and testbench

//  Downstream of the Mandelbrot renderer top level. Consumes its 24-bit colour pixel stream
//  (r/g/b, first/last_x/last_y/valid, ready back) and packs it into a 32-bit stream for the

---
 rtl/pixel_stream_packer_if.sv | 31 +++
 rtl/pixel_stream_packer.sv | 150 +++++++++++++++
 tb/tb_pixel_stream_packer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_packer_if.sv
// Stream bundle between the Mandelbrot colour pixel source, the packer and the video DMA word sink.
// The master modport is the packer's view; slave is the surrounding environment.
interface pixel_stream_packer_if;
  logic [7:0]  in_r;
  logic [7:0]  in_g;
  logic [7:0]  in_b;
  logic        in_valid;
  logic        in_first;
  logic        in_last_x;
  logic        in_last_y;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_user;
  logic        out_last;
  logic        out_ready;

  modport master (
    input  in_r, in_g, in_b, in_valid, in_first, in_last_x, in_last_y,
    output in_ready,
    output out_data, out_valid, out_user, out_last,
    input  out_ready
  );

  modport slave (
    output in_r, in_g, in_b, in_valid, in_first, in_last_x, in_last_y,
    input  in_ready,
    input  out_data, out_valid, out_user, out_last,
    output out_ready
  );
endinterface

// File: rtl/pixel_stream_packer.sv
// Packs 24-bit {b,g,r} pixels little-endian into 32-bit words (4 pixels -> 3 words),
// tagging start-of-frame on out_user and end-of-line on out_last with zero-padded line flushes.
module pixel_stream_packer #(
  parameter int PIXEL_WIDTH = 24,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pixel_stream_packer_if.master bus,
  output logic                  frame_done
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [PIXEL_WIDTH-1:0]  res_q, res_d;
  logic                    sof_q, sof_d;
  logic                    lasty_q, lasty_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    vld_q, vld_d;
  logic                    user_q, user_d;
  logic                    last_q, last_d;
  logic                    oly_q, oly_d;
  logic                    fd_q, fd_d;

  logic [PIXEL_WIDTH-1:0]  pix;
  logic [DATA_WIDTH-1:0]   word;
  logic [1:0]              cnt_eff;
  logic                    free, accept, emit, wlast, wly;

  assign pix          = {bus.in_b, bus.in_g, bus.in_r};
  assign free         = !vld_q || bus.out_ready;
  assign bus.in_ready = reset && (state_q == ST_RUN) && free;
  assign accept       = bus.in_valid && bus.in_ready;
  // A start-of-frame pixel begins packing from an empty residual.
  assign cnt_eff      = bus.in_first ? 2'd0 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sof_d   = sof_q;
    lasty_d = lasty_q;
    data_d  = data_q;
    vld_d   = vld_q && !bus.out_ready;
    user_d  = user_q;
    last_d  = last_q;
    oly_d   = oly_q;
    fd_d    = vld_q && bus.out_ready && last_q && oly_q;
    emit    = 1'b0;
    word    = '0;
    wlast   = 1'b0;
    wly     = 1'b0;

    if (accept) begin
      unique case (cnt_eff)
        2'd0: begin
          res_d = pix;
          cnt_d = 2'd3;
        end
        2'd3: begin
          emit  = 1'b1;
          word  = {pix[7:0], res_q};
          res_d = {8'h00, pix[23:8]};
          cnt_d = 2'd2;
        end
        2'd2: begin
          emit  = 1'b1;
          word  = {pix[15:0], res_q[15:0]};
          res_d = {16'h0000, pix[23:16]};
          cnt_d = 2'd1;
        end
        default: begin
          emit  = 1'b1;
          word  = {pix, res_q[7:0]};
          cnt_d = 2'd0;
        end
      endcase
      if (bus.in_first) sof_d = 1'b1;
      if (bus.in_last_x) begin
        lasty_d = bus.in_last_y;
        if (cnt_eff == 2'd0) begin
          emit  = 1'b1;
          word  = {8'h00, pix};
          wlast = 1'b1;
          wly   = bus.in_last_y;
          cnt_d = 2'd0;
        end else if (cnt_d == 2'd0) begin
          wlast = 1'b1;
          wly   = bus.in_last_y;
        end else begin
          state_d = ST_FLUSH;
        end
      end
    end else if (state_q == ST_FLUSH && free) begin
      // Residual bytes are stored with zeroed upper bytes, so the pad comes for free.
      emit    = 1'b1;
      word    = {8'h00, res_q};
      wlast   = 1'b1;
      wly     = lasty_q;
      cnt_d   = 2'd0;
      state_d = ST_RUN;
    end

    if (emit) begin
      vld_d  = 1'b1;
      data_d = word;
      user_d = sof_d;
      last_d = wlast;
      oly_d  = wly;
      sof_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      sof_q   <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      user_q  <= 1'b0;
      last_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sof_q   <= sof_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      user_q  <= user_d;
      last_q  <= last_d;
      fd_q    <= fd_d;
    end
  end

  always_ff @(posedge clk) begin
    res_q   <= res_d;
    lasty_q <= lasty_d;
    oly_q   <= oly_d;
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = vld_q;
  assign bus.out_user  = user_q;
  assign bus.out_last  = last_q;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed bench for pixel_stream_packer: packing order, line flush, SOF/EOL tagging,
// back-pressure hold, mid-stream reset and frame_done.
module tb_pixel_stream_packer;

  logic clk;
  logic reset;
  logic frame_done;
  int   n_checks;
  int   n_fail;
  int   fd_cnt;

  logic [31:0] wq[$];
  logic        uq[$];
  logic        lq[$];

  pixel_stream_packer_if bif();

  pixel_stream_packer #(.PIXEL_WIDTH(24), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bif),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && bif.out_valid && bif.out_ready) begin
      wq.push_back(bif.out_data);
      uq.push_back(bif.out_user);
      lq.push_back(bif.out_last);
    end
  end

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic clear_q();
    wq.delete();
    uq.delete();
    lq.delete();
  endtask

  task automatic idle(input int n);
    bif.in_valid  = 1'b0;
    bif.in_first  = 1'b0;
    bif.in_last_x = 1'b0;
    bif.in_last_y = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one pixel and returns 1ns after the edge that accepted it.
  task automatic send_px(input logic [23:0] p, input logic f, input logic lx, input logic ly);
    int  tries;
    bit  done;
    bif.in_r      = p[7:0];
    bif.in_g      = p[15:8];
    bif.in_b      = p[23:16];
    bif.in_first  = f;
    bif.in_last_x = lx;
    bif.in_last_y = ly;
    bif.in_valid  = 1'b1;
    tries = 0;
    done  = 1'b0;
    while (!done && tries < 200) begin
      @(negedge clk);
      if (bif.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
      tries++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_px timeout: pixel %h not accepted, in_ready=%b required 1", p, bif.in_ready);
    end
    bif.in_valid = 1'b0;
  endtask

  function automatic logic [23:0] seq_px(input int base, input int i);
    logic [7:0] r, g, b;
    r = 8'(base + 3 * i);
    g = 8'(base + 3 * i + 1);
    b = 8'(base + 3 * i + 2);
    return {b, g, r};
  endfunction

  function automatic logic [31:0] seq_word(input int base, input int j);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(base + 4 * j);
    b1 = 8'(base + 4 * j + 1);
    b2 = 8'(base + 4 * j + 2);
    b3 = 8'(base + 4 * j + 3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic test_reset();
    reset         = 1'b0;
    bif.out_ready = 1'b1;
    idle(3);
    bif.in_valid = 1'b1;
    #1;
    n_checks++;
    if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bif.in_ready); end
    n_checks++;
    if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bif.out_valid); end
    n_checks++;
    if (bif.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bif.out_data); end
    n_checks++;
    if ({bif.out_user, bif.out_last, frame_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: user/last/fd got %b want 000", {bif.out_user, bif.out_last, frame_done});
    end
    bif.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", bif.in_ready); end
  endtask

  task automatic test_pack4();
    logic [23:0] px[4];
    logic [31:0] ew[3];
    px = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
    ew = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    clear_q();
    for (int i = 0; i < 4; i++) begin
      send_px(px[i], 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (bif.out_valid !== (i != 0)) begin
        n_fail++; $display("FAIL pack4_latency px%0d: out_valid got %b want %b", i, bif.out_valid, (i != 0));
      end
      if (i != 0) begin
        n_checks++;
        if (bif.out_data !== ew[i-1]) begin
          n_fail++; $display("FAIL pack4_word%0d: got %h want %h", i - 1, bif.out_data, ew[i-1]);
        end
      end
    end
    idle(4);
    n_checks++;
    if (wq.size() !== 3) begin n_fail++; $display("FAIL pack4_count: got %0d want 3", wq.size()); end
    n_checks++;
    if ((uq.size() == 3) && ({uq[0], uq[1], uq[2], lq[0], lq[1], lq[2]} !== 6'b0)) begin
      n_fail++; $display("FAIL pack4_flags: user/last bits nonzero");
    end
  endtask

  task automatic test_line640();
    int bad, ucnt, lcnt, fd0;
    clear_q();
    fd0 = fd_cnt;
    for (int i = 0; i < 640; i++) send_px(seq_px(0, i), i == 0, i == 639, 1'b0);
    idle(4);
    n_checks++;
    if (wq.size() !== 480) begin n_fail++; $display("FAIL line640_count: got %0d want 480", wq.size()); end
    bad = 0; ucnt = 0; lcnt = 0;
    foreach (wq[j]) begin
      if (wq[j] !== seq_word(0, j)) bad++;
      if (uq[j] !== (j == 0)) ucnt++;
      if (lq[j] !== (j == 479)) lcnt++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL line640_data: %0d bad words, want 0", bad); end
    n_checks++;
    if (ucnt !== 0) begin n_fail++; $display("FAIL line640_user: %0d misplaced out_user, want 0", ucnt); end
    n_checks++;
    if (lcnt !== 0) begin n_fail++; $display("FAIL line640_last: %0d misplaced out_last, want 0", lcnt); end
    n_checks++;
    if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL line640_frame_done: pulses %0d want 0", fd_cnt - fd0); end
  endtask

  task automatic test_flush();
    logic [23:0] px[6];
    int low;
    px = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A, 24'h0F0E0D, 24'h121110};
    clear_q();
    for (int i = 0; i < 5; i++) send_px(px[i], i == 0, i == 4, 1'b0);
    idle(4);
    n_checks++;
    if (wq.size() !== 4) begin n_fail++; $display("FAIL flush5_count: got %0d want 4", wq.size()); end
    else begin
      n_checks++;
      if ({wq[3], lq[3], lq[2], uq[0]} !== {32'h000F0E0D, 1'b1, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL flush5_tail: word %h last %b/%b user0 %b want 000f0e0d 1/0 1", wq[3], lq[3], lq[2], uq[0]);
      end
    end
    clear_q();
    for (int i = 0; i < 6; i++) send_px(px[i], i == 0, i == 5, 1'b0);
    low = 0;
    repeat (4) begin
      @(negedge clk);
      if (!bif.in_ready) low++;
    end
    n_checks++;
    if (low !== 1) begin n_fail++; $display("FAIL flush6_in_ready_low: got %0d cycles want 1", low); end
    idle(3);
    n_checks++;
    if (wq.size() !== 5) begin n_fail++; $display("FAIL flush6_count: got %0d want 5", wq.size()); end
    else begin
      n_checks++;
      if ({wq[3], lq[3], wq[4], lq[4]} !== {32'h100F0E0D, 1'b0, 32'h00001211, 1'b1}) begin
        n_fail++; $display("FAIL flush6_tail: %h/%b %h/%b want 100f0e0d/0 00001211/1", wq[3], lq[3], wq[4], lq[4]);
      end
    end
  endtask

  task automatic test_stall();
    int bad, lcnt, hold_bad;
    logic [31:0] w1;
    clear_q();
    w1 = seq_word(8'h40, 1);
    for (int i = 0; i < 3; i++) send_px(seq_px(8'h40, i), i == 0, 1'b0, 1'b0);
    bif.out_ready = 1'b0;
    bif.in_r = 8'h49; bif.in_g = 8'h4A; bif.in_b = 8'h4B;
    bif.in_valid = 1'b1;
    hold_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bif.out_valid !== 1'b1 || bif.out_data !== w1 || bif.in_ready !== 1'b0) hold_bad++;
    end
    n_checks++;
    if (hold_bad !== 0) begin
      n_fail++; $display("FAIL stall_hold: %0d unstable cycles (data %h want %h), want 0", hold_bad, bif.out_data, w1);
    end
    @(posedge clk); #1;
    bif.out_ready = 1'b1;
    for (int i = 3; i < 8; i++) send_px(seq_px(8'h40, i), 1'b0, i == 7, 1'b0);
    idle(4);
    n_checks++;
    if (wq.size() !== 6) begin n_fail++; $display("FAIL stall_count: got %0d want 6", wq.size()); end
    bad = 0; lcnt = 0;
    foreach (wq[j]) begin
      if (wq[j] !== seq_word(8'h40, j)) bad++;
      if (lq[j] !== (j == 5)) lcnt++;
    end
    n_checks++;
    if (bad !== 0 || lcnt !== 0) begin
      n_fail++; $display("FAIL stall_content: %0d bad words, %0d bad last flags, want 0/0", bad, lcnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] px[4];
    logic [31:0] ew[3];
    px = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
    ew = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    send_px(24'h777777, 1'b0, 1'b0, 1'b0);
    send_px(24'h888888, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 0", bif.in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    n_checks++;
    if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b want 0", bif.out_valid); end
    clear_q();
    for (int i = 0; i < 4; i++) send_px(px[i], i == 0, 1'b0, 1'b0);
    idle(4);
    n_checks++;
    if (wq.size() !== 3) begin n_fail++; $display("FAIL midreset_count: got %0d want 3", wq.size()); end
    else begin
      n_checks++;
      if ({wq[0], wq[1], wq[2], uq[0]} !== {ew[0], ew[1], ew[2], 1'b1}) begin
        n_fail++; $display("FAIL midreset_words: %h %h %h user %b want %h %h %h 1", wq[0], wq[1], wq[2], uq[0], ew[0], ew[1], ew[2]);
      end
    end
  endtask

  task automatic test_sof_frame();
    int fd0;
    clear_q();
    send_px(24'hAAAAAA, 1'b0, 1'b0, 1'b0);
    send_px(24'hBBBBBB, 1'b0, 1'b0, 1'b0);
    fd0 = fd_cnt;
    send_px(24'h030201, 1'b1, 1'b0, 1'b0);
    send_px(24'h060504, 1'b0, 1'b0, 1'b0);
    send_px(24'h090807, 1'b0, 1'b0, 1'b0);
    send_px(24'h0C0B0A, 1'b0, 1'b1, 1'b1);
    idle(8);
    n_checks++;
    if (wq.size() !== 4) begin n_fail++; $display("FAIL sof_count: got %0d want 4", wq.size()); end
    else begin
      n_checks++;
      if ({wq[0], uq[0], wq[1], uq[1]} !== {32'hBBAAAAAA, 1'b0, 32'h04030201, 1'b1}) begin
        n_fail++; $display("FAIL sof_drop: %h/%b %h/%b want bbaaaaaa/0 04030201/1", wq[0], uq[0], wq[1], uq[1]);
      end
      n_checks++;
      if ({wq[3], lq[3]} !== {32'h0C0B0A09, 1'b1}) begin
        n_fail++; $display("FAIL sof_eol: %h/%b want 0c0b0a09/1", wq[3], lq[3]);
      end
    end
    n_checks++;
    if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL frame_done_pulse: %0d cycles high want 1", fd_cnt - fd0); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    fd_cnt        = 0;
    reset         = 1'b0;
    bif.out_ready = 1'b1;
    bif.in_r      = 8'h00;
    bif.in_g      = 8'h00;
    bif.in_b      = 8'h00;
    bif.in_valid  = 1'b0;
    bif.in_first  = 1'b0;
    bif.in_last_x = 1'b0;
    bif.in_last_y = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_pack4();
    test_line640();
    test_flush();
    test_stall();
    test_reset_mid();
    test_sof_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
